pwm_multi: RTL

Parametrised multi-channel PWM generator; next-generation replacement for the single-channel fixed-10-cycle PWM block. CH channels share one period counter. Each channel has its own duty and polarity. The block supports edge-aligned and center-aligned modes. Register writes are double-buffered so that new settings take effect only on a period boundary and never glitch a running output. It sits between the control-register bank and the motor/LED pad drivers.

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/pwm_cmp_ch.sv | 28 ++
 rtl/pwm_multi.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    localparam logic EDGE    = 1'b0;
    localparam logic CENTER  = 1'b1;

    // Widest supported counter and duty vector (16 channels x 16 bits).
    localparam int MAX_CW  = 16;
    localparam int MAX_VEC = 256;

    function automatic logic [MAX_CW-1:0] duty_slice(input logic [MAX_VEC-1:0] vec,
                                                     input int unsigned        ch,
                                                     input int unsigned        cw);
        logic [MAX_CW-1:0] w_mask;
        w_mask     = (MAX_CW'(1) << cw) - MAX_CW'(1);
        duty_slice = MAX_CW'(vec >> (ch * cw)) & w_mask;
    endfunction

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: registered compare of the shared counter against this
// channel's duty, with polarity applied and IDLE forcing the inactive level.
module pwm_cmp_ch
    import pwm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_idle,
    input  logic [MAX_CW-1:0] i_cnt,
    input  logic [MAX_CW-1:0] i_duty,
    input  logic              i_pol,
    output logic              o_pwm
);

    logic r_pwm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pwm <= 1'b0;
        else if (i_idle)
            r_pwm <= i_pol;
        else
            r_pwm <= (i_cnt < i_duty) ^ i_pol;
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter (edge or center aligned),
// double-buffered period/duty/polarity/mode committed on period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CW-1:0]    period,
    input  logic [CH*CW-1:0] duty,
    input  logic [CH-1:0]    polarity,
    input  logic             center,
    output logic [CH-1:0]    pwm_out,
    output logic             period_tick,
    output logic             pend
);

    state_t              r_state, w_state_n;
    logic [CW-1:0]       r_cnt, w_cnt_n;
    logic                w_bnd;
    logic                r_tick;

    logic [CW-1:0]       r_a_per,  r_p_per;
    logic [CH*CW-1:0]    r_a_duty, r_p_duty;
    logic [CH-1:0]       r_a_pol,  r_p_pol;
    logic                r_a_cen,  r_p_cen;
    logic                r_pend;

    logic                w_idle;
    logic [MAX_CW-1:0]   w_cnt_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_tick  <= w_bnd;
        end
    end

    // Center mode counts 0..P then P-1..1; the boundary is the step back to 0,
    // giving 2P cycles per period. P <= 1 in center mode behaves like edge mode.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_bnd     = 1'b0;
        if (!en) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_n = RUN_UP;
                    w_cnt_n   = '0;
                end
                RUN_UP: begin
                    if (r_cnt == r_a_per) begin
                        if (r_a_cen == CENTER && r_a_per > CW'(1)) begin
                            w_state_n = RUN_DOWN;
                            w_cnt_n   = r_cnt - CW'(1);
                        end else begin
                            w_bnd = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + CW'(1);
                    end
                end
                RUN_DOWN: begin
                    if (r_cnt <= CW'(1))
                        w_bnd = 1'b1;
                    else
                        w_cnt_n = r_cnt - CW'(1);
                end
                default: w_state_n = IDLE;
            endcase
            if (w_bnd) begin
                w_state_n = RUN_UP;
                w_cnt_n   = '0;
            end
        end
    end

    // A load coinciding with a boundary bypasses the pending stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_per  <= '0;
            r_a_duty <= '0;
            r_a_pol  <= '0;
            r_a_cen  <= EDGE;
            r_p_per  <= '0;
            r_p_duty <= '0;
            r_p_pol  <= '0;
            r_p_cen  <= EDGE;
            r_pend   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (load) begin
                r_a_per  <= period;
                r_a_duty <= duty;
                r_a_pol  <= polarity;
                r_a_cen  <= center;
                r_pend   <= 1'b0;
            end
        end else if (w_bnd) begin
            if (load) begin
                r_a_per  <= period;
                r_a_duty <= duty;
                r_a_pol  <= polarity;
                r_a_cen  <= center;
            end else if (r_pend) begin
                r_a_per  <= r_p_per;
                r_a_duty <= r_p_duty;
                r_a_pol  <= r_p_pol;
                r_a_cen  <= r_p_cen;
            end
            r_pend <= 1'b0;
        end else if (load) begin
            r_p_per  <= period;
            r_p_duty <= duty;
            r_p_pol  <= polarity;
            r_p_cen  <= center;
            r_pend   <= 1'b1;
        end
    end

    assign w_idle    = !en || (r_state == IDLE);
    assign w_cnt_ext = MAX_CW'(r_cnt);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [MAX_CW-1:0] w_duty;
        assign w_duty = duty_slice(MAX_VEC'(r_a_duty), i, CW);

        pwm_cmp_ch u_cmp (
            .clk    (clk),
            .reset  (reset),
            .i_idle (w_idle),
            .i_cnt  (w_cnt_ext),
            .i_duty (w_duty),
            .i_pol  (r_a_pol[i]),
            .o_pwm  (pwm_out[i])
        );
    end

    assign period_tick = r_tick;
    assign pend        = r_pend;

endmodule
